alu_arbiter: RTL

- Shares one instance of the team's 32-bit `alu` (add/sub/and/or) between two requesters.
- Each requester presents operands and an ALUControl code through a valid/ready request channel and receives its result on a dedicated valid/ready response channel.
- Operands are registered, the operation is sequenced, and the result is held until the owning requester accepts it.
- Used by multi-cycle units (e.g. address generation and a branch-compare helper) that must not each carry a private ALU.

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: one shared 32-bit add/sub/and/or ALU serving two requesters.
//   clk, rst           - clock (rising edge), asynchronous active-low reset
//   ReqN{Valid,Ready}  - request handshake; Ready is combinational in IDLE
//   ReqN{A,B,Ctrl}     - operands and ALUControl, captured on the handshake
//   RspN{Valid,Ready}  - response handshake, result held until accepted
//   RspNResult         - per-requester result register
//   Busy               - FSM not in IDLE
//   DoneNCnt           - completed responses per requester (wrapping)
// Optional: `define ALU_ARB_ZERO_FLAG_EN adds RspNZero (result == 0),
// registered alongside the result.
module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [31:0]      Req0A,
  input  logic [31:0]      Req0B,
  input  logic [2:0]       Req0Ctrl,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [31:0]      Req1A,
  input  logic [31:0]      Req1B,
  input  logic [2:0]       Req1Ctrl,
  output logic             Rsp0Valid,
  input  logic             Rsp0Ready,
  output logic [31:0]      Rsp0Result,
  output logic             Rsp1Valid,
  input  logic             Rsp1Ready,
  output logic [31:0]      Rsp1Result,
  output logic             Busy,
  output logic [CNT_W-1:0] Done0Cnt,
  output logic [CNT_W-1:0] Done1Cnt
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,
  output logic             Rsp0Zero,
  output logic             Rsp1Zero
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               own_q, own_d;     // requester owning the in-flight op
  logic               last_q, last_d;   // last requester served
  logic [31:0]        res0_q, res0_d, res1_q, res1_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [31:0]        alu_y;
  logic               gnt_id, req_any, rsp_take;
  logic               ctrl2_unused;

  // Ctrl[2] is carried with the operation but has no effect on the ALU.
  assign ctrl2_unused = ctrl_q[2];

  // Shared ALU, fed only from the captured operands.
  always_comb begin
    case (ctrl_q[1:0])
      2'b00:   alu_y = a_q + b_q;
      2'b01:   alu_y = a_q + ~b_q + 32'd1;
      2'b10:   alu_y = a_q & b_q;
      default: alu_y = a_q | b_q;
    endcase
  end

  // Arbitration: a lone requester wins; on a tie either requester 0 (fixed)
  // or the one not served last (round-robin).
  assign req_any = Req0Valid | Req1Valid;
  always_comb begin
    if (Req0Valid && Req1Valid) gnt_id = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
    else                        gnt_id = Req1Valid;
  end

  // Ready is gated by rst so it reads 0 throughout reset.
  assign Req0Ready = rst && (state_q == IDLE) && req_any && !gnt_id;
  assign Req1Ready = rst && (state_q == IDLE) && req_any &&  gnt_id;

  assign rsp_take = own_q ? Rsp1Ready : Rsp0Ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    own_d   = own_q;
    last_d  = last_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          a_d     = gnt_id ? Req1A    : Req0A;
          b_d     = gnt_id ? Req1B    : Req0B;
          ctrl_d  = gnt_id ? Req1Ctrl : Req0Ctrl;
          own_d   = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (own_q) res1_d = alu_y;
        else       res0_d = alu_y;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_take) begin
          if (own_q) cnt1_d = cnt1_q + 1'b1;
          else       cnt0_d = cnt0_q + 1'b1;
          last_d  = own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      res0_q  <= '0;
      res1_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      own_q   <= own_d;
      last_q  <= last_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic zero0_q, zero0_d, zero1_q, zero1_d;

  always_comb begin
    zero0_d = zero0_q;
    zero1_d = zero1_q;
    if (state_q == EXEC) begin
      if (own_q) zero1_d = (alu_y == 32'h0);
      else       zero0_d = (alu_y == 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero0_q <= 1'b0;
      zero1_q <= 1'b0;
    end else begin
      zero0_q <= zero0_d;
      zero1_q <= zero1_d;
    end
  end

  assign Rsp0Zero = zero0_q;
  assign Rsp1Zero = zero1_q;
`endif

  assign Rsp0Valid  = (state_q == RESP) && !own_q;
  assign Rsp1Valid  = (state_q == RESP) &&  own_q;
  assign Rsp0Result = res0_q;
  assign Rsp1Result = res1_q;
  assign Busy       = (state_q != IDLE);
  assign Done0Cnt   = cnt0_q;
  assign Done1Cnt   = cnt1_q;

endmodule
